// File: rtl/l2_noc2_arb_pkg.sv
// Shared types, constants and header helpers for the L2 NoC2 output arbiter.
// The flit geometry (DATA_W, LEN_LSB, LEN_W) is fixed here for all files.
package l2_noc2_arb_pkg;

    localparam int DATA_W  = 64;
    localparam int LEN_LSB = 22;
    localparam int LEN_W   = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam logic REQ_P1 = 1'b0;
    localparam logic REQ_P2 = 1'b1;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] flit);
        return flit[LEN_LSB +: LEN_W];
    endfunction

endpackage

// File: rtl/l2_noc2_out_arb_if.sv
// Handshake bundle for the L2 NoC2 output arbiter: two requester flit streams,
// the shared NoC2 output and lock status. slave = arbiter side, master = environment.
interface l2_noc2_out_arb_if;
    import l2_noc2_arb_pkg::*;

    logic              p1_valid;
    logic [DATA_W-1:0] p1_data;
    logic              p1_ready;
    logic              p2_valid;
    logic [DATA_W-1:0] p2_data;
    logic              p2_ready;
    logic              noc2_valid_out;
    logic [DATA_W-1:0] noc2_data_out;
    logic              noc2_ready_out;
    logic              busy;
    logic              owner;

    modport master (
        output p1_valid, p1_data, p2_valid, p2_data, noc2_ready_out,
        input  p1_ready, p2_ready, noc2_valid_out, noc2_data_out, busy, owner
    );

    modport slave (
        input  p1_valid, p1_data, p2_valid, p2_data, noc2_ready_out,
        output p1_ready, p2_ready, noc2_valid_out, noc2_data_out, busy, owner
    );

endinterface

// File: rtl/l2_noc2_out_reg.sv
// One-entry registered output stage: loads on accept, holds under backpressure,
// and sustains one flit per cycle when downstream is ready.
module l2_noc2_out_reg
    import l2_noc2_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_free
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Holding register: a load wins over a drain, data is kept after a drain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= {DATA_W{1'b0}};
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/l2_noc2_out_arb.sv
// Packet-level arbiter sharing the L2 NoC2 output between pipe1 and pipe2.
// Optional macro L2_NOC2_ARB_PIPE2_PRIO_EN: pipe2 always wins in IDLE instead of round-robin.
module l2_noc2_out_arb
    import l2_noc2_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    l2_noc2_out_arb_if.slave    bus
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_owner;
    logic              w_owner_nxt;
    logic              r_rr;
    logic              w_rr_nxt;
    logic [LEN_W-1:0]  r_rem;
    logic [LEN_W-1:0]  w_rem_nxt;
    logic              w_sel;
    logic              w_sel_valid;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_free;
    logic              w_accept;
    logic [LEN_W-1:0]  w_len;

    // Requester selection: the lock owner in LOCK, otherwise the arbitration winner
    always_comb begin
        w_sel = r_owner;
        if (r_state == LOCK) begin
            w_sel = r_owner;
        end else begin
`ifdef L2_NOC2_ARB_PIPE2_PRIO_EN
            w_sel = bus.p2_valid ? REQ_P2 : REQ_P1;
`else
            if (r_rr == REQ_P1) begin
                w_sel = bus.p1_valid ? REQ_P1 : REQ_P2;
            end else begin
                w_sel = bus.p2_valid ? REQ_P2 : REQ_P1;
            end
`endif
        end
    end

    assign w_sel_valid = (w_sel == REQ_P2) ? bus.p2_valid : bus.p1_valid;
    assign w_sel_data  = (w_sel == REQ_P2) ? bus.p2_data  : bus.p1_data;
    assign w_accept    = w_sel_valid && w_free && !rst;
    assign w_len       = hdr_len(w_sel_data);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= REQ_P1;
            r_rr    <= REQ_P1;
            r_rem   <= LEN_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Next-state logic; a zero-length header re-arbitrates next cycle without a bubble
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        w_rem_nxt   = r_rem;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_owner_nxt = w_sel;
`ifdef L2_NOC2_ARB_PIPE2_PRIO_EN
                    w_rr_nxt    = r_rr;
`else
                    w_rr_nxt    = ~w_sel;
`endif
                    if (w_len != LEN_ZERO) begin
                        w_state_nxt = LOCK;
                        w_rem_nxt   = w_len;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOCK: begin
                if (w_accept) begin
                    w_rem_nxt   = r_rem - LEN_ONE;
                    w_state_nxt = (r_rem == LEN_ONE) ? IDLE : LOCK;
                end else begin
                    w_state_nxt = LOCK;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_rem_nxt   = LEN_ZERO;
            end
        endcase
    end

    // Output logic: only the selected requester sees the free output slot
    always_comb begin
        bus.p1_ready = 1'b0;
        bus.p2_ready = 1'b0;
        if (rst) begin
            bus.p1_ready = 1'b0;
            bus.p2_ready = 1'b0;
        end else if (w_sel == REQ_P2) begin
            bus.p2_ready = w_free;
        end else begin
            bus.p1_ready = w_free;
        end
    end

    assign bus.busy  = (r_state == LOCK);
    assign bus.owner = r_owner;

    l2_noc2_out_reg u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_data  (w_sel_data),
        .i_ready (bus.noc2_ready_out),
        .o_valid (bus.noc2_valid_out),
        .o_data  (bus.noc2_data_out),
        .o_free  (w_free)
    );

endmodule

// File: tb/tb_l2_noc2_out_arb.sv
// Scoreboard bench for l2_noc2_out_arb: per-pipe flit queues feed the DUT,
// expected output flits are queued by the tests and popped by a monitor.
module tb_l2_noc2_out_arb;

`ifdef L2_NOC2_ARB_PIPE2_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_noc2_out_arb_if bus ();

    l2_noc2_out_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [63:0] q1[$];
    logic [63:0] q2[$];
    logic [63:0] exp_q[$];
    logic        en1 = 1'b0;
    logic        en2 = 1'b0;
    logic        acc1, acc2;
    int          n_vec  = 0;
    int          n_fail = 0;

    function automatic logic [63:0] hdr(input logic [7:0] len, input logic [15:0] tag);
        logic [63:0] h;
        h        = 64'h0;
        h[15:0]  = tag;
        h[29:22] = len;
        return h;
    endfunction

    function automatic logic [63:0] pay(input logic [15:0] tag);
        return {16'hDA7A, 32'hCAFE_0000, tag};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en1 = 1'b0;
        en2 = 1'b0;
        q1.delete();
        q2.delete();
        bus.noc2_ready_out = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || q1.size() != 0 || q2.size() != 0) && cyc < 200) begin
            step();
            cyc++;
        end
        chk({name, " drained"}, 64'(exp_q.size()), 64'h0);
        repeat (3) step();
    endtask

    // pipe1 source: pop on a handshake seen at the previous falling edge
    initial begin
        bus.p1_valid = 1'b0;
        bus.p1_data  = 64'h0;
        forever begin
            @(negedge clk);
            acc1 = bus.p1_valid && bus.p1_ready;
            @(posedge clk);
            #1;
            if (acc1 && q1.size() > 0) void'(q1.pop_front());
            bus.p1_valid = en1 && (q1.size() > 0);
            bus.p1_data  = (q1.size() > 0) ? q1[0] : 64'h0;
        end
    end

    // pipe2 source
    initial begin
        bus.p2_valid = 1'b0;
        bus.p2_data  = 64'h0;
        forever begin
            @(negedge clk);
            acc2 = bus.p2_valid && bus.p2_ready;
            @(posedge clk);
            #1;
            if (acc2 && q2.size() > 0) void'(q2.pop_front());
            bus.p2_valid = en2 && (q2.size() > 0);
            bus.p2_data  = (q2.size() > 0) ? q2[0] : 64'h0;
        end
    end

    // Output monitor: every flit consumed downstream must match the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (bus.noc2_valid_out && bus.noc2_ready_out) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_flit: got %h expected none", bus.noc2_data_out);
                end else begin
                    chk("out_flit", bus.noc2_data_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bus.noc2_ready_out = 1'b1;
        // reset state, with a requester already presenting a flit
        rst = 1'b1;
        q1.push_back(hdr(8'd0, 16'h0BAD));
        en1 = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst p1_ready", 64'(bus.p1_ready), 64'h0);
        chk("rst p2_ready", 64'(bus.p2_ready), 64'h0);
        chk("rst valid", 64'(bus.noc2_valid_out), 64'h0);
        chk("rst data", bus.noc2_data_out, 64'h0);
        chk("rst busy", 64'(bus.busy), 64'h0);
        chk("rst owner", 64'(bus.owner), 64'h0);
        do_reset();

        // 1: single-flit packet, latency 1
        q1.push_back(64'h1);
        exp_q.push_back(64'h1);
        en1 = 1'b1;
        step();
        @(negedge clk);
        chk("t1 p1_ready", 64'(bus.p1_ready), 64'h1);
        chk("t1 busy", 64'(bus.busy), 64'h0);
        @(negedge clk);
        chk("t1 valid", 64'(bus.noc2_valid_out), 64'h1);
        chk("t1 data", bus.noc2_data_out, 64'h1);
        chk("t1 busy after", 64'(bus.busy), 64'h0);
        wait_drain("t1");

        // 2: simultaneous len=2 packets, rr starts at pipe1
        do_reset();
        q1.push_back(hdr(8'd2, 16'h0021)); q1.push_back(pay(16'h0022)); q1.push_back(pay(16'h0023));
        q2.push_back(hdr(8'd2, 16'h0031)); q2.push_back(pay(16'h0032)); q2.push_back(pay(16'h0033));
        if (PRIO) begin
            foreach (q2[i]) exp_q.push_back(q2[i]);
            foreach (q1[i]) exp_q.push_back(q1[i]);
        end else begin
            foreach (q1[i]) exp_q.push_back(q1[i]);
            foreach (q2[i]) exp_q.push_back(q2[i]);
        end
        en1 = 1'b1;
        en2 = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2 loser ready", 64'(PRIO ? bus.p1_ready : bus.p2_ready), 64'h0);
        end
        @(negedge clk);
        chk("t2 second ready", 64'(PRIO ? bus.p1_ready : bus.p2_ready), 64'h1);
        wait_drain("t2");

        // 3: owner stalls mid-packet, lock must hold against pipe2
        do_reset();
        q1.push_back(hdr(8'd3, 16'h0041)); q1.push_back(pay(16'h0042));
        exp_q.push_back(hdr(8'd3, 16'h0041)); exp_q.push_back(pay(16'h0042));
        exp_q.push_back(pay(16'h0043)); exp_q.push_back(pay(16'h0044));
        exp_q.push_back(hdr(8'd0, 16'h004B));
        en1 = 1'b1;
        for (int i = 0; i < 20 && q1.size() != 0; i++) step();
        q2.push_back(hdr(8'd0, 16'h004B));
        en2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("t3 busy", 64'(bus.busy), 64'h1);
            chk("t3 p2_ready", 64'(bus.p2_ready), 64'h0);
        end
        chk("t3 p2 held", 64'(q2.size()), 64'h1);
        q1.push_back(pay(16'h0043)); q1.push_back(pay(16'h0044));
        wait_drain("t3");
        chk("t3 owner", 64'(bus.owner), 64'h1);
        chk("t3 idle", 64'(bus.busy), 64'h0);

        // 4: downstream backpressure with a len=1 packet in flight
        do_reset();
        bus.noc2_ready_out = 1'b0;
        q1.push_back(hdr(8'd1, 16'h0051)); q1.push_back(pay(16'h0052)); q1.push_back(hdr(8'd0, 16'h0053));
        foreach (q1[i]) exp_q.push_back(q1[i]);
        en1 = 1'b1;
        for (int i = 0; i < 20 && q1.size() == 3; i++) step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4 hold valid", 64'(bus.noc2_valid_out), 64'h1);
            chk("t4 hold data", bus.noc2_data_out, hdr(8'd1, 16'h0051));
            chk("t4 p1_ready", 64'(bus.p1_ready), 64'h0);
            step();
        end
        bus.noc2_ready_out = 1'b1;
        wait_drain("t4");

        // 5: reset in the middle of a len=5 packet
        do_reset();
        q1.push_back(hdr(8'd5, 16'h0061));
        for (int i = 0; i < 5; i++) q1.push_back(pay(16'(16'h0062 + i)));
        exp_q.push_back(hdr(8'd5, 16'h0061));
        en1 = 1'b1;
        for (int i = 0; i < 20 && q1.size() == 6; i++) step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("t5 valid", 64'(bus.noc2_valid_out), 64'h0);
        chk("t5 busy", 64'(bus.busy), 64'h0);
        chk("t5 owner", 64'(bus.owner), 64'h0);
        chk("t5 exp empty", 64'(exp_q.size()), 64'h0);
        step();
        q1.delete();
        en1 = 1'b0;
        q2.push_back(hdr(8'd0, 16'h006A));
        exp_q.push_back(hdr(8'd0, 16'h006A));
        en2 = 1'b1;
        step();
        @(negedge clk);
        chk("t5 p2_ready in rst", 64'(bus.p2_ready), 64'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5 p2_ready", 64'(bus.p2_ready), 64'h1);
        wait_drain("t5");
        chk("t5 owner p2", 64'(bus.owner), 64'h1);

        // 6: back-to-back len=0 packets from both pipes
        do_reset();
        q1.push_back(hdr(8'd0, 16'h0071)); q1.push_back(hdr(8'd0, 16'h0072));
        q2.push_back(hdr(8'd0, 16'h0081)); q2.push_back(hdr(8'd0, 16'h0082));
        if (PRIO) begin
            exp_q.push_back(q2[0]); exp_q.push_back(q2[1]);
            exp_q.push_back(q1[0]); exp_q.push_back(q1[1]);
        end else begin
            exp_q.push_back(q1[0]); exp_q.push_back(q2[0]);
            exp_q.push_back(q1[1]); exp_q.push_back(q2[1]);
        end
        en1 = 1'b1;
        en2 = 1'b1;
        wait_drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_noc2_out_arb.md
Name: l2_noc2_out_arb

Overview:
Packet-level arbiter that shares the single L2 NoC2 output port between pipe1 (4-stage request pipeline) and pipe2 (3-stage memory-response pipeline). Each pipeline presents whole NoC2 packets as a flit stream: one header flit, then the payload flits counted by the header length field. Once a header is granted, the arbiter locks that pipeline until its last payload flit is accepted. It then drives the noc2 output through a one-entry registered output stage.

Parameters:
DATA_W, 64, flit width in bits
LEN_LSB, 22, bit position of the header payload-length field LSB
LEN_W, 8, width of the header payload-length field (payload flit count, 0..255)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
p1_valid  input  1  pipe1 flit valid
p1_data  input  DATA_W  pipe1 flit
p1_ready  output  1  pipe1 flit accepted when p1_valid && p1_ready
p2_valid  input  1  pipe2 flit valid
p2_data  input  DATA_W  pipe2 flit
p2_ready  output  1  pipe2 flit accepted when p2_valid && p2_ready
noc2_valid_out  output  1  output flit valid
noc2_data_out  output  DATA_W  output flit
noc2_ready_out  input  1  downstream ready
busy  output  1  a packet is locked (state LOCK)
owner  output  1  current/last granted pipeline: 0=pipe1, 1=pipe2

Behaviour:
- Reset: noc2_valid_out=0, noc2_data_out=0, state=IDLE, busy=0, owner=0, rr pointer=pipe1, remaining count=0. p1_ready and p2_ready are 0 during reset.
- Output stage: a single register. out_free = !noc2_valid_out || noc2_ready_out. An accepted flit loads the register and appears on noc2_valid_out the next cycle (latency 1). The register clears its valid when it drains with no new load. Full throughput is 1 flit/cycle.
- States are IDLE and LOCK.
- IDLE behaviour:
  - Combinational grant among the valid requesters. Round-robin: rr pointer names the preferred pipeline; the other pipeline wins only if the preferred one is not valid.
  - The winner's ready = out_free. The loser's ready = 0.
  - On header acceptance: owner <= winner; rr pointer <= the other pipeline; len = header[LEN_LSB+LEN_W-1:LEN_LSB].
  - If len==0: single-flit packet; stay in IDLE, and the next arbitration happens the next cycle with no bubble.
  - Else: remaining <= len, state <= LOCK.
- LOCK behaviour:
  - Only the owner's ready = out_free; the other pipeline's ready = 0 regardless of its valid.
  - Each accepted payload flit decrements remaining. When the flit with remaining==1 is accepted, state <= IDLE.
  - If the owner deasserts valid mid-packet, the lock holds indefinitely and no interleaving is permitted.
- Downstream backpressure: noc2_data_out and noc2_valid_out hold stable while noc2_valid_out && !noc2_ready_out. Requester readies drop in that condition.
- Simultaneous headers from both pipelines: the rr pointer decides. Consecutive packets alternate when both pipelines stay valid.
- Reset asserted mid-packet: all state returns to reset values immediately; a partial packet is discarded. Requesters are reset by the same rst.
- Arithmetic: remaining is LEN_W bits and is never decremented below 1 while in LOCK, so there is no wrap.
- The arbiter never inspects payload content beyond the header length field.

Optional Feature:
L2_NOC2_ARB_PIPE2_PRIO_EN
- Defined: in IDLE, pipe2 always wins when p2_valid, so memory responses drain first (deadlock avoidance). The rr pointer is unused and held at reset value. Packet locking is unchanged.
- Undefined: round-robin as described above.

Decomposition:
- Shared package l2_noc2_arb_pkg: state enum (IDLE, LOCK), requester id constants (REQ_P1=0, REQ_P2=1), and a header length-extract function parameterised by LEN_LSB/LEN_W.
- One natural sub-module, l2_noc2_out_reg: the one-entry registered output stage (load/valid/ready).
- Arbitration FSM stays in the top module.

Test Plan:
1. Single-flit packets, no contention: p1 sends header len=0 with data 0x...0000_0001 -> noc2_valid_out=1 next cycle with the same data; busy stays 0; p1_ready=1 throughout.
2. Both pipelines valid at rr=pipe1 start, each with header len=2 plus 2 payload flits -> 6 consecutive output flits in order p1H, p1D0, p1D1, p2H, p2D0, p2D1; p2_ready=0 for the first 3 cycles.
3. Lock hold: p1 header len=3, p1_valid drops after 1 payload flit for 5 cycles while p2_valid=1 -> no p2 flit is emitted; busy=1; the packet completes after p1 resumes, then p2 is granted.
4. Backpressure: noc2_ready_out=0 for 4 cycles while a len=1 packet is in flight -> noc2_data_out stable, p1_ready=0; the flow resumes with no lost or duplicated flit.
5. Reset mid-packet: rst asserted after the header of a len=5 packet -> next cycle noc2_valid_out=0, busy=0, owner=0; a new pipe2 header is granted immediately after rst deasserts.
6. With L2_NOC2_ARB_PIPE2_PRIO_EN defined: both pipelines repeatedly send len=0 packets -> all pipe2 packets are emitted before any pipe1 packet while p2_valid stays high.
